// File: rtl/move_drain_pkg.sv
// move_drain_pkg: shared move format, board geometry and drain FSM encoding
// Used by the column/square units and by move_drain_unit.
// Optional build macro DRAIN_FILTER_INVALID_EN (consumed by move_word_unpacker).
package move_drain_pkg;
   localparam int NCOLS     = 8;
   localparam int SLOTS     = 8;
   localparam int MW        = 19;
   localparam int CNT_W     = 8;
   localparam int WORD_W    = SLOTS * MW;
   localparam int INV_BIT   = 18;
   localparam int PRO_BIT   = 17;
   localparam int PAWN_BIT  = 16;
   localparam int PAWN2_BIT = 15;
   localparam int EP_BIT    = 14;
   localparam int CAS_BIT   = 13;
   localparam int CAP_BIT   = 12;
   localparam int FROM_HI   = 11;
   localparam int FROM_LO   = 6;
   localparam int TO_HI     = 5;
   localparam int TO_LO     = 0;

   typedef enum logic [2:0] {IDLE, SCAN, READ, UNPACK, DONE} state_e;

   function automatic logic move_invalid(input logic [MW-1:0] m);
      return m[INV_BIT];
   endfunction
endpackage

// File: rtl/move_word_unpacker.sv
// move_word_unpacker: holds one packed FIFO word and streams its slots over valid/ready
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   load_i       capture word_i and restart at slot 0
//   word_i       packed word, slot k at [k*MW +: MW]
//   ready_i      downstream ready
//   data_o       current move (0 when not valid)
//   valid_o      data_o valid
//   xfer_o       a move transfers this cycle
//   last_o       the held word is finished this cycle
// Macro DRAIN_FILTER_INVALID_EN: when defined, slots with the invalid flag are
// skipped without spending a cycle or asserting valid_o.
module move_word_unpacker
   import move_drain_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic              load_i,
   input  logic [WORD_W-1:0] word_i,
   input  logic              ready_i,
   output logic [MW-1:0]     data_o,
   output logic              valid_o,
   output logic              xfer_o,
   output logic              last_o
);
   localparam int SW = $clog2(SLOTS);

   logic [WORD_W-1:0] word_q, word_d;
   logic [SW-1:0]     slot_q, slot_d, cur;
   logic              active_q, active_d, found, more;
   logic [MW-1:0]     slot_w [SLOTS];

   for (genvar g = 0; g < SLOTS; g++) begin : g_slot
      assign slot_w[g] = word_q[g*MW +: MW];
   end

`ifdef DRAIN_FILTER_INVALID_EN
   // cur is the first valid slot at or after slot_q; more says whether any
   // valid slot remains beyond it, so the word can end on its last valid move
   always_comb begin
      cur   = slot_q;
      found = 1'b0;
      more  = 1'b0;
      for (int k = SLOTS - 1; k >= 0; k--)
         if (k >= int'(slot_q) && !move_invalid(slot_w[k])) begin
            cur   = SW'(k);
            found = 1'b1;
         end
      for (int k = 0; k < SLOTS; k++)
         if (k > int'(cur) && !move_invalid(slot_w[k]))
            more = 1'b1;
   end
`else
   assign cur   = slot_q;
   assign found = 1'b1;
   assign more  = slot_q != SW'(SLOTS - 1);
`endif

   assign valid_o = active_q & found;
   assign data_o  = valid_o ? slot_w[cur] : '0;
   assign xfer_o  = valid_o & ready_i;
   // an all-invalid remainder (found=0) finishes the word without a transfer
   assign last_o  = active_q & (~found | (xfer_o & ~more));

   always_comb begin
      word_d   = load_i ? word_i : word_q;
      slot_d   = load_i ? '0 : xfer_o ? cur + 1'b1 : slot_q;
      active_d = load_i | (active_q & ~last_o);
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         word_q   <= '0;
         slot_q   <= '0;
         active_q <= 1'b0;
      end else begin
         word_q   <= word_d;
         slot_q   <= slot_d;
         active_q <= active_d;
      end
endmodule

// File: rtl/move_drain_unit.sv
// move_drain_unit: round-robin reader of the column move FIFOs, streams unpacked moves
// Ports:
//   clk, reset   clock, asynchronous active-low reset (0 = reset)
//   start        one-cycle pulse, begins a pass from IDLE or DONE
//   col_done     per-column finished flags
//   col_empty    per-column FIFO empty flags
//   col_data     column FIFO read words, column c at [c*WORD_W +: WORD_W], valid the
//                cycle after its col_rden bit
//   col_rden     one-hot FIFO read enable, one cycle per word
//   move_data    current move, move_valid its valid, move_ready downstream ready
//   move_count   moves emitted this pass, saturating
//   busy, done   pass in progress / pass complete (held until next start)
// Macro DRAIN_FILTER_INVALID_EN: skip invalid-flagged slots (see move_word_unpacker).
module move_drain_unit
   import move_drain_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NCOLS-1:0]        col_done,
   input  logic [NCOLS-1:0]        col_empty,
   input  logic [NCOLS*WORD_W-1:0] col_data,
   output logic [NCOLS-1:0]        col_rden,
   output logic [MW-1:0]           move_data,
   output logic                    move_valid,
   input  logic                    move_ready,
   output logic [CNT_W-1:0]        move_count,
   output logic                    busy,
   output logic                    done
);
   localparam int PW = $clog2(NCOLS);

   state_e            state_q, state_d;
   logic [PW-1:0]     ptr_q, ptr_d, ptr_nx;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              all_fin, load, clr, xfer, last;
   logic [WORD_W-1:0] col_word [NCOLS];

   for (genvar g = 0; g < NCOLS; g++) begin : g_col
      assign col_word[g] = col_data[g*WORD_W +: WORD_W];
   end

   assign all_fin = &col_done & &col_empty;
   assign ptr_nx  = (ptr_q == PW'(NCOLS - 1)) ? '0 : ptr_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      col_rden = '0;
      load     = 1'b0;
      clr      = 1'b0;
      case (state_q)
         IDLE, DONE:
            if (start) begin
               state_d = SCAN;
               ptr_d   = '0;
               clr     = 1'b1;
            end
         SCAN:
            if (all_fin)
               state_d = DONE;
            else if (!col_empty[ptr_q]) begin
               col_rden = NCOLS'(1) << ptr_q;
               state_d  = READ;
            end else
               ptr_d = ptr_nx;
         READ: begin
            load    = 1'b1;
            state_d = UNPACK;
         end
         UNPACK:
            // resume the rotation after the drained column for fairness
            if (last) begin
               ptr_d   = ptr_nx;
               state_d = SCAN;
            end
         default: state_d = IDLE;
      endcase
   end

   assign cnt_d = clr ? '0 : (xfer && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
      end

   move_word_unpacker u_unpack (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load),
      .word_i  (col_word[ptr_q]),
      .ready_i (move_ready),
      .data_o  (move_data),
      .valid_o (move_valid),
      .xfer_o  (xfer),
      .last_o  (last)
   );

   assign move_count = cnt_q;
   assign busy       = state_q inside {SCAN, READ, UNPACK};
   assign done       = state_q == DONE;
endmodule

// File: tb/tb_move_drain_unit.sv
// tb_move_drain_unit: directed self-checking bench for move_drain_unit
module tb_move_drain_unit;
   import move_drain_pkg::*;

   logic                    clk = 1'b0, reset = 1'b0, start = 1'b0, move_ready = 1'b1;
   logic [NCOLS-1:0]        col_done = '1, col_empty, col_rden;
   logic [NCOLS*WORD_W-1:0] col_data = '0;
   logic [MW-1:0]           move_data;
   logic                    move_valid, busy, done;
   logic [CNT_W-1:0]        move_count;
   int total = 0, bad = 0;

   logic [WORD_W-1:0] mem [NCOLS][8];
   int                wr [NCOLS] = '{default: 0};
   int                rd [NCOLS] = '{default: 0};
   logic [NCOLS-1:0]  rlog [64];
   int                rn = 0;
   logic [MW-1:0]     mlog [256];
   int                mcyc [256];
   int                mn = 0, cyc = 0;

   move_drain_unit dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .col_done   (col_done),
      .col_empty  (col_empty),
      .col_data   (col_data),
      .col_rden   (col_rden),
      .move_data  (move_data),
      .move_valid (move_valid),
      .move_ready (move_ready),
      .move_count (move_count),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   // column FIFO model: 1-cycle read latency, read log of every nonzero col_rden
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (col_rden != '0) begin
         rlog[rn % 64] <= col_rden;
         rn <= rn + 1;
      end
      for (int c = 0; c < NCOLS; c++)
         if (col_rden[c]) begin
            col_data[c*WORD_W +: WORD_W] <= mem[c][rd[c] % 8];
            rd[c] <= rd[c] + 1;
         end
   end

   always_comb
      for (int c = 0; c < NCOLS; c++)
         col_empty[c] = rd[c] == wr[c];

   always @(negedge clk)
      if (move_valid && move_ready) begin
         mlog[mn % 256] <= move_data;
         mcyc[mn % 256] <= cyc;
         mn <= mn + 1;
      end

   function automatic logic [MW-1:0] mv(input int base, input int k, input logic inv);
      return {inv, 6'b000000, 6'(base + k), 6'(base + k + 8)};
   endfunction

   function automatic logic [WORD_W-1:0] mk_word(input int base, input logic [7:0] inv);
      logic [WORD_W-1:0] w;
      for (int k = 0; k < SLOTS; k++)
         w[k*MW +: MW] = mv(base, k, inv[k]);
      return w;
   endfunction

   task automatic push(input int c, input logic [WORD_W-1:0] w);
      mem[c][wr[c] % 8] = w;
      wr[c] = wr[c] + 1;
   endtask

   task automatic pulse_start();
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
   endtask

   task automatic wait_done(input int lim, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < lim && !ok; i++) begin
         @(negedge clk); #1;
         ok = done;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      total++; if (col_rden !== '0) begin bad++; $display("FAIL rst_rden: got %h want 0", col_rden); end
      total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", move_valid); end
      total++; if (move_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", move_data); end
      total++; if (move_count !== '0) begin bad++; $display("FAIL rst_count: got %0d want 0", move_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", done); end
      reset = 1'b1;
   endtask

   task automatic test_single();
      int r0, m0;
      bit ok;
      r0 = rn; m0 = mn;
      push(3, mk_word(8'o12, 8'h00));
      pulse_start();
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL single_timeout: done=%b want 1", done); end
      total++; if (rn - r0 !== 1) begin bad++; $display("FAIL single_nreads: got %0d want 1", rn - r0); end
      total++; if (rlog[r0 % 64] !== 8'h08) begin bad++; $display("FAIL single_rden: got %h want 08", rlog[r0 % 64]); end
      total++; if (mn - m0 !== 8) begin bad++; $display("FAIL single_nmoves: got %0d want 8", mn - m0); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (mlog[(m0 + k) % 256] !== mv(8'o12, k, 1'b0)) begin
            bad++; $display("FAIL single_move%0d: got %h want %h", k, mlog[(m0 + k) % 256], mv(8'o12, k, 1'b0));
         end
      end
      total++; if (mcyc[(m0 + 7) % 256] - mcyc[m0 % 256] !== 7) begin bad++; $display("FAIL single_b2b: got %0d cycles want 7", mcyc[(m0 + 7) % 256] - mcyc[m0 % 256]); end
      total++; if (move_count !== 8'd8) begin bad++; $display("FAIL single_count: got %0d want 8", move_count); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL single_busy: got %b want 0", busy); end
   endtask

   task automatic test_backpressure();
      int r0, m0;
      bit ok;
      r0 = rn; m0 = mn;
      move_ready = 1'b0;
      push(1, mk_word(20, 8'h00));
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk); #1;
         ok = move_valid;
      end
      total++; if (!ok) begin bad++; $display("FAIL bp_first_valid: valid=%b want 1", move_valid); end
      total++; if (move_data !== mv(20, 0, 1'b0)) begin bad++; $display("FAIL bp_slot0: got %h want %h", move_data, mv(20, 0, 1'b0)); end
      @(posedge clk); #1 move_ready = 1'b1;
      @(posedge clk); #1 move_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         total++; if (move_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_valid%0d: got %b want 1", i, move_valid); end
         total++; if (move_data !== mv(20, 1, 1'b0)) begin bad++; $display("FAIL bp_hold_data%0d: got %h want %h", i, move_data, mv(20, 1, 1'b0)); end
         @(posedge clk); #1;
      end
      move_ready = 1'b1;
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL bp_timeout: done=%b want 1", done); end
      total++; if (rn - r0 !== 1) begin bad++; $display("FAIL bp_nreads: got %0d want 1", rn - r0); end
      total++; if (mn - m0 !== 8) begin bad++; $display("FAIL bp_nmoves: got %0d want 8", mn - m0); end
      for (int k = 0; k < 8; k++) begin
         total++;
         if (mlog[(m0 + k) % 256] !== mv(20, k, 1'b0)) begin
            bad++; $display("FAIL bp_move%0d: got %h want %h", k, mlog[(m0 + k) % 256], mv(20, k, 1'b0));
         end
      end
      total++; if (move_count !== 8'd8) begin bad++; $display("FAIL bp_count: got %0d want 8", move_count); end
   endtask

   task automatic test_round_robin();
      int r0, m0;
      int eb [4] = '{0, 16, 32, 48};
      logic [NCOLS-1:0] er [4] = '{8'h01, 8'h20, 8'h01, 8'h20};
      bit ok;
      r0 = rn; m0 = mn;
      push(0, mk_word(0, 8'h00));
      push(0, mk_word(32, 8'h00));
      push(5, mk_word(16, 8'h00));
      push(5, mk_word(48, 8'h00));
      pulse_start();
      wait_done(400, ok);
      total++; if (!ok) begin bad++; $display("FAIL rr_timeout: done=%b want 1", done); end
      total++; if (rn - r0 !== 4) begin bad++; $display("FAIL rr_nreads: got %0d want 4", rn - r0); end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (rlog[(r0 + i) % 64] !== er[i]) begin
            bad++; $display("FAIL rr_read%0d: got %h want %h", i, rlog[(r0 + i) % 64], er[i]);
         end
      end
      total++; if (mn - m0 !== 32) begin bad++; $display("FAIL rr_nmoves: got %0d want 32", mn - m0); end
      for (int i = 0; i < 32; i++) begin
         total++;
         if (mlog[(m0 + i) % 256] !== mv(eb[i / 8], i % 8, 1'b0)) begin
            bad++; $display("FAIL rr_move%0d: got %h want %h", i, mlog[(m0 + i) % 256], mv(eb[i / 8], i % 8, 1'b0));
         end
      end
      total++; if (move_count !== 8'd32) begin bad++; $display("FAIL rr_count: got %0d want 32", move_count); end
   endtask

   task automatic test_late_done();
      int r0, m0;
      bit ok;
      r0 = rn; m0 = mn;
      col_done = 8'h7F;
      pulse_start();
      repeat (20) @(posedge clk);
      #1;
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL late_busy: got %b want 1", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL late_done_early: got %b want 0", done); end
      pulse_start();
      total++; if (busy !== 1'b1) begin bad++; $display("FAIL late_start_busy: got %b want 1", busy); end
      push(7, mk_word(40, 8'h00));
      col_done = '1;
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL late_timeout: done=%b want 1", done); end
      total++; if (rn - r0 !== 1) begin bad++; $display("FAIL late_nreads: got %0d want 1", rn - r0); end
      total++; if (rlog[r0 % 64] !== 8'h80) begin bad++; $display("FAIL late_rden: got %h want 80", rlog[r0 % 64]); end
      total++; if (mn - m0 !== 8) begin bad++; $display("FAIL late_nmoves: got %0d want 8", mn - m0); end
      total++; if (mlog[(m0 + 7) % 256] !== mv(40, 7, 1'b0)) begin bad++; $display("FAIL late_last: got %h want %h", mlog[(m0 + 7) % 256], mv(40, 7, 1'b0)); end
      total++; if (move_count !== 8'd8) begin bad++; $display("FAIL late_count: got %0d want 8", move_count); end
   endtask

   task automatic test_filter();
      int m0, n;
      logic [7:0] inv = 8'h44;
      logic [MW-1:0] exp [8];
      bit ok;
      m0 = mn;
      n = 0;
      for (int k = 0; k < 8; k++) begin
`ifdef DRAIN_FILTER_INVALID_EN
         if (!inv[k]) begin exp[n] = mv(50, k, 1'b0); n++; end
`else
         exp[n] = mv(50, k, inv[k]); n++;
`endif
      end
      push(2, mk_word(50, inv));
      pulse_start();
      wait_done(200, ok);
      total++; if (!ok) begin bad++; $display("FAIL filt_timeout: done=%b want 1", done); end
      total++; if (mn - m0 !== n) begin bad++; $display("FAIL filt_nmoves: got %0d want %0d", mn - m0, n); end
      for (int i = 0; i < n; i++) begin
         total++;
         if (mlog[(m0 + i) % 256] !== exp[i]) begin
            bad++; $display("FAIL filt_move%0d: got %h want %h", i, mlog[(m0 + i) % 256], exp[i]);
         end
      end
      total++; if (move_count !== CNT_W'(n)) begin bad++; $display("FAIL filt_count: got %0d want %0d", move_count, n); end
   endtask

   task automatic test_reset_mid();
      int r0, m0;
      bit ok;
      m0 = mn;
      push(4, mk_word(60, 8'h00));
      pulse_start();
      ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk); #1;
         ok = (mn - m0) == 4;
      end
      total++; if (!ok) begin bad++; $display("FAIL rmid_reach: got %0d moves want 4", mn - m0); end
      @(posedge clk); #1 reset = 1'b0;
      #1;
      total++; if (move_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid: got %b want 0", move_valid); end
      total++; if (move_count !== '0) begin bad++; $display("FAIL rmid_count: got %0d want 0", move_count); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rmid_done: got %b want 0", done); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
      #2 reset = 1'b1;
      r0 = rn; m0 = mn;
      push(6, mk_word(2, 8'h00));
      push(1, mk_word(9, 8'h00));
      pulse_start();
      wait_done(300, ok);
      total++; if (!ok) begin bad++; $display("FAIL rmid_timeout: done=%b want 1", done); end
      total++; if (rn - r0 !== 2) begin bad++; $display("FAIL rmid_nreads: got %0d want 2", rn - r0); end
      total++; if (rlog[r0 % 64] !== 8'h02) begin bad++; $display("FAIL rmid_first_read: got %h want 02", rlog[r0 % 64]); end
      total++; if (rlog[(r0 + 1) % 64] !== 8'h40) begin bad++; $display("FAIL rmid_second_read: got %h want 40", rlog[(r0 + 1) % 64]); end
      total++; if (mlog[m0 % 256] !== mv(9, 0, 1'b0)) begin bad++; $display("FAIL rmid_move0: got %h want %h", mlog[m0 % 256], mv(9, 0, 1'b0)); end
      total++; if (mlog[(m0 + 8) % 256] !== mv(2, 0, 1'b0)) begin bad++; $display("FAIL rmid_move8: got %h want %h", mlog[(m0 + 8) % 256], mv(2, 0, 1'b0)); end
      total++; if (move_count !== 8'd16) begin bad++; $display("FAIL rmid_count: got %0d want 16", move_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_round_robin();
      test_late_done();
      test_filter();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/move_drain_unit.md
Name: move_drain_unit

Overview:
- Board-level consumer of the eight per-column move FIFOs; it is the reader side of the column FIFO interface.
- Round-robin drains each column FIFO, unpacks every packed word into individual moves and streams them out over a valid/ready handshake.
- Counts emitted moves and raises done once every column has finished and been fully drained.
- Sits between the column array and the downstream move evaluator / host bridge.

Parameters:
- NCOLS, 8, number of column FIFOs.
- SLOTS, 8, moves per packed FIFO word.
- MW, 19, move width: [18] invalid, [17] promote, [16] pawn move, [15] pawn 2 sq, [14] en passant, [13] castle, [12] capture, [11:6] from, [5:0] to.
- CNT_W, 8, move counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset; 0 = reset.
- start  in  1  one-cycle pulse that begins a drain pass.
- col_done  in  NCOLS  per-column done flags.
- col_empty  in  NCOLS  per-column FIFO empty flags.
- col_data  in  NCOLS*SLOTS*MW  concatenated column FIFO read words; column c occupies [c*152 +: 152].
- col_rden  out  NCOLS  one-hot read enable into the column FIFOs.
- move_data  out  MW  current move.
- move_valid  out  1  move_data valid.
- move_ready  in  1  downstream accepts the move.
- move_count  out  CNT_W  moves emitted this pass, saturating.
- busy  out  1  a pass is in progress.
- done  out  1  pass complete; held until the next start.

Behaviour:
- Reset (asynchronous, reset=0): state IDLE, col_rden=0, move_valid=0, move_data=0, move_count=0, busy=0, done=0, column pointer ptr=0, slot index=0.
- FIFO read timing: col_data for column c is valid on the cycle after col_rden[c] is asserted (1-cycle read latency). col_rden is asserted for exactly one cycle per word.
- IDLE: on start, clear move_count and done, set busy, go to SCAN. A start pulse outside IDLE/DONE is ignored.
- DONE: a new start behaves as in IDLE.
- SCAN: examine column ptr.
  - If ~col_empty[ptr]: assert col_rden[ptr] and go to READ.
  - Otherwise advance ptr by 1, wrapping NCOLS-1 to 0.
  - If all col_done=1 and all col_empty=1 at the start of a full rotation, go to DONE (busy=0, done=1).
  - Maximum one column is examined per cycle.
- READ: col_rden=0. Capture the word for column ptr into the internal word register, set slot=0, go to UNPACK.
- UNPACK: present slot k, at bits [k*MW +: MW], on move_data.
  - move_valid=1 while the slot is emitted. move_data and move_valid stay stable until move_ready=1.
  - A transfer is a cycle with move_valid & move_ready. On transfer: slot++ and move_count++, saturating at 2^CNT_W-1.
  - After slot SLOTS-1 transfers: ptr++ (wrap), return to SCAN. The rotation restarts from the next column for fairness.
  - Back-to-back transfers: one move per cycle while move_ready stays high.
- move_ready low: hold indefinitely. No FIFO read is issued while a word is being unpacked.
- A column whose col_done is 0 but whose FIFO is empty is skipped. The pass does not finish until that column is done and empty.
- start while busy: ignored.
- reset mid-pass: immediate return to reset values. The partially read word is discarded.

Optional Feature:
- Macro DRAIN_FILTER_INVALID_EN.
- Defined: slots with bit [18]=1 are skipped in zero cycles. Each skipped slot advances slot without asserting move_valid and is not counted. A word containing only invalid slots returns directly to SCAN.
- Undefined: all SLOTS slots are emitted and counted, invalid flag included.

Decomposition:
- Shared package: MW, SLOTS, NCOLS, the flag bit positions (INV_BIT=18 … CAP_BIT=12, FROM/TO field ranges) and the state encoding (IDLE, SCAN, READ, UNPACK, DONE). Shared with the column/square units.
- Sub-module: move_word_unpacker. It holds the word register and slot index, does slot muxing and invalid skipping, and provides the valid/ready output stage. The top level holds the FSM, the round-robin pointer and the counter.

Test Plan:
- Single word: column 3 holds one word with eight valid moves (from=6'o12, to=6'o22 …), all col_done=1, move_ready=1 → col_rden=8'h08 one cycle, then 8 consecutive moves in slot order, move_count=8, done=1.
- Backpressure: toggle move_ready 1,0,0,1 during UNPACK → move_data/move_valid stable through the low cycles, no extra col_rden, no duplicated or lost slot.
- Round-robin: columns 0 and 5 each hold 2 words → read order col0, col5, col0, col5; move_count=32.
- Late done: column 7 has col_done=0 and is empty for 20 cycles, then one word arrives and done rises → busy stays 1, the word is drained, then done=1.
- Invalid filter: word with slots 2 and 6 having bit18=1 → with DRAIN_FILTER_INVALID_EN, 6 moves emitted and move_count=6; without it, 8 emitted.
- Reset mid-UNPACK (after slot 3), then start → move_valid=0 immediately, move_count=0, done=0; the pass restarts from ptr=0.
